// File: rtl/imm_pkg.sv
// imm_pkg: immediate format codes shared by the immediate extender and the
// immediate encoder. Codes 5..7 are illegal and have no enumerator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_e;

endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational packer. It places an immediate into the RV32I
// immediate bit-fields of base_instr_i, selected by imm_src_i.
//   imm_src_i    in  3   format code (imm_pkg::imm_fmt_e, 5..7 illegal)
//   imm_i        in  32  immediate (two's complement)
//   base_instr_i in  32  instruction with non-immediate fields populated
//   instr_o      out 32  packed instruction
//   err_o        out 1   illegal format, or immediate not representable
// Build option IMM_RANGE_CHECK_EN: when defined, range violations also set
// err_o. When undefined, no range logic exists and only illegal codes flag.
module imm_pack
  import imm_pkg::*;
(
  input  logic [2:0]  imm_src_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_instr_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

`ifdef IMM_RANGE_CHECK_EN
  logic fits12, fits13, fits21;
  // Each check tests that the discarded upper bits all replicate the sign bit.
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);
`endif

  always_comb begin
    instr_o = base_instr_i;
    err_o   = 1'b0;
    case (imm_src_i)
      IMM_I: begin
        instr_o[31:20] = imm_i[11:0];
`ifdef IMM_RANGE_CHECK_EN
        err_o = ~fits12;
`endif
      end
      IMM_S: begin
        instr_o[31:25] = imm_i[11:5];
        instr_o[11:7]  = imm_i[4:0];
`ifdef IMM_RANGE_CHECK_EN
        err_o = ~fits12;
`endif
      end
      IMM_B: begin
        instr_o[31]    = imm_i[12];
        instr_o[7]     = imm_i[11];
        instr_o[30:25] = imm_i[10:5];
        instr_o[11:8]  = imm_i[4:1];
`ifdef IMM_RANGE_CHECK_EN
        err_o = ~fits13 | imm_i[0];
`endif
      end
      IMM_U: begin
        instr_o[31:12] = imm_i[31:12];
`ifdef IMM_RANGE_CHECK_EN
        err_o = |imm_i[11:0];
`endif
      end
      IMM_J: begin
        instr_o[31]    = imm_i[20];
        instr_o[19:12] = imm_i[19:12];
        instr_o[20]    = imm_i[11];
        instr_o[30:21] = imm_i[10:1];
`ifdef IMM_RANGE_CHECK_EN
        err_o = ~fits21 | imm_i[0];
`endif
      end
      default: begin
        instr_o = base_instr_i;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: a 2-stage valid/ready pipeline that packs a 32-bit immediate
// into an RV32I instruction word. Used by the program loader and self-test path.
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      / in_ready out 1   : input handshake
//   imm_src    in  3      format I=0 S=1 B=2 U=3 J=4 (5..7 illegal)
//   imm        in  32     immediate value
//   base_instr in  32     instruction template
//   out_valid  out 1      / out_ready in 1   : output handshake
//   out_instr  out 32     encoded instruction
//   out_err    out 1      immediate not representable / illegal imm_src
//   err_count  out CNT_W  saturating count of handshaken erroneous outputs
// Build option IMM_RANGE_CHECK_EN enables range checking in imm_pack.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_src,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_src_q;
  logic [31:0]      s1_imm_q, s1_base_q;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q;
  logic             s2_err_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      pk_instr;
  logic             pk_err;
  logic             s2_adv, s1_adv, in_fire, out_fire;

  imm_pack u_pack (
    .imm_src_i    (s1_src_q),
    .imm_i        (s1_imm_q),
    .base_instr_i (s1_base_q),
    .instr_o      (pk_instr),
    .err_o        (pk_err)
  );

  // Handshakes are masked while rst is high, so a reset cycle never completes
  // a transfer even though the stage registers clear only at the edge.
  assign s2_adv    = ~s2_valid_q | out_ready;
  assign s1_adv    = s1_valid_q & s2_adv;
  assign in_ready  = ~rst & (~s1_valid_q | s2_adv);
  assign out_valid = ~rst & s2_valid_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_cnt_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire)     s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_adv) s2_valid_d = s1_valid_q;

    err_cnt_d = err_cnt_q;
    if (out_fire && s2_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      err_cnt_q  <= err_cnt_d;
      if (s1_adv) begin
        s2_instr_q <= pk_instr;
        s2_err_q   <= pk_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_src_q  <= imm_src;
      s1_imm_q  <= imm;
      s1_base_q <= base_instr;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm, base_instr;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .imm(imm), .base_instr(base_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        e;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  bit          chk_lat = 0;
  logic        last_rdy;
  logic [31:0] held_w;

  // Reference: field placement by shift/mask arithmetic, range rules by
  // signed numeric bounds and divisibility.
  function automatic void ref_enc(input logic [2:0] s, input logic [31:0] im,
                                  input logic [31:0] b,
                                  output logic [31:0] w, output logic e);
    longint v;
    logic   bad;
    v   = longint'($signed(im));
    w   = b;
    bad = 1'b0;
    case (s)
      3'd0: begin
        w = (b & 32'h000F_FFFF) | ((im & 32'hFFF) << 20);
        bad = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        w = (b & 32'h01FF_F07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
        bad = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = (b & 32'h01FF_F07F) | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
            | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
        bad = (v < -4096) || (v > 4095) || (v % 2 != 0);
      end
      3'd3: begin
        w = (b & 32'h0000_0FFF) | (im & 32'hFFFF_F000);
        bad = (im % 4096) != 0;
      end
      3'd4: begin
        w = (b & 32'h0000_0FFF) | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
            | (((im >> 11) & 32'h1) << 20) | (im & 32'h000F_F000);
        bad = (v < -1048576) || (v > 1048575) || (v % 2 != 0);
      end
      default: w = b;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    e = (s > 3'd4) ? 1'b1 : bad;
`else
    e = (s > 3'd4);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, score handshakes.
  task automatic cycle(input logic v, input logic [2:0] s, input logic [31:0] im,
                       input logic [31:0] b, input logic ordy);
    exp_t x;
    in_valid = v; imm_src = s; imm = im; base_instr = b; out_ready = ordy;
    #1;
    last_rdy = in_ready;
    check("err_count", 32'(err_count), 32'(exp_cnt));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check("out_instr", out_instr, exp_q[0].w);
        check("out_err", 32'(out_err), 32'(exp_q[0].e));
        if (out_ready) begin
          x = exp_q.pop_front();
          if (chk_lat) check("latency", 32'(cyc - x.acc), 32'd2);
          if (x.e && exp_cnt != 65535) exp_cnt++;
        end
      end
    end
    if (in_valid && in_ready) begin
      ref_enc(s, im, b, x.w, x.e);
      x.acc = cyc;
      exp_q.push_back(x);
      check("inflight_le2", 32'(exp_q.size() <= 2), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle(1'b0, 3'd0, '0, '0, 1'b1);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic single(input logic [2:0] s, input logic [31:0] im, input logic [31:0] b);
    cycle(1'b1, s, im, b, 1'b1);
    check("single_accept", 32'(last_rdy), 32'd1);
    drain(6);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_err_count", 32'(err_count), 32'd0);
    check("post_rst_out_instr", out_instr, 32'd0);
    check("post_rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; in_valid = 1'b0; imm_src = '0; imm = '0; base_instr = '0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed vectors, exact 2-cycle latency
    chk_lat = 1;
    single(3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
    single(3'd1, 32'h0000_0010, 32'h0000_2023);
    single(3'd2, 32'h0000_0008, 32'h0000_0063);
    single(3'd4, 32'h0000_0800, 32'h0000_006F);
    single(3'd3, 32'h1234_5000, 32'h0000_0037);
    single(3'd3, 32'h1234_5001, 32'h0000_0037);
    single(3'd0, 32'h0000_0800, 32'h0000_0013);
    single(3'd2, 32'h0000_0006, 32'h0000_0063);
    single(3'd2, 32'h0000_0007, 32'h0000_0063);
    single(3'd4, 32'hFFF0_0000, 32'h0000_006F);
    single(3'd1, 32'hFFFF_F800, 32'h0000_2023);
    single(3'd7, 32'h1234_5678, 32'hDEAD_BEEF);
    chk_lat = 0;

    // Backpressure: two accepted, third refused, then released in order
    cycle(1'b1, 3'd0, 32'h0000_0001, 32'h0000_0013, 1'b0);
    check("bp_rdy1", 32'(last_rdy), 32'd1);
    cycle(1'b1, 3'd1, 32'h0000_0002, 32'h0000_2023, 1'b0);
    check("bp_rdy2", 32'(last_rdy), 32'd1);
    cycle(1'b1, 3'd3, 32'h0000_3000, 32'h0000_0037, 1'b0);
    check("bp_rdy3", 32'(last_rdy), 32'd0);
    held_w = out_instr;
    cycle(1'b1, 3'd3, 32'h0000_3000, 32'h0000_0037, 1'b0);
    check("bp_hold", out_instr, held_w);
    check("bp_rdy4", 32'(last_rdy), 32'd0);
    cycle(1'b1, 3'd3, 32'h0000_3000, 32'h0000_0037, 1'b1);
    check("bp_release_rdy", 32'(last_rdy), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 3'd0, '0, '0, 1'b1);
      check("bp_one_per_cycle", 32'(exp_q.size()), 32'(1 - i));
    end
    drain(4);

    // Reset mid-stream: in-flight items vanish, nothing stale afterwards
    cycle(1'b1, 3'd3, 32'h0000_1001, 32'h0000_0037, 1'b0);
    cycle(1'b1, 3'd7, 32'h0000_0000, 32'h0000_0033, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, '0, '0, 1'b1);
    chk_lat = 1;
    single(3'd6, 32'h0000_0055, 32'hCAFE_F00D);
    chk_lat = 0;

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = $urandom;
        1: r = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: r = $urandom & 32'hFFFF_F000;
        default: r = 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
      endcase
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r, $urandom,
            1'($urandom_range(0, 3) != 0));
    end
    drain(8);
    cycle(1'b0, 3'd0, '0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
